// File: rtl/uart_receiver_if.sv
// Host-side view of the UART receive path: the serial line in, the received word and status out.
// The DUT connects through the slave modport and the line driver through the master modport.
interface uart_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 parity_err;
   logic                 busy;
   logic [2:0]           state;

   modport master (
      output rx,
      input  rx_data, rx_valid, frame_err, parity_err, busy, state
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, frame_err, parity_err, busy, state
   );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, validates the start bit at mid-bit, samples data LSB-first
// at bit centres, checks optional parity and the stop bit, then strobes the word out.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input logic           main_clk,
   input logic           reset,
   uart_receiver_if.slave bus
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic                 rx_meta_q, rx_s_q;
   logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_pend_q, par_pend_d;
   logic                 valid_q, valid_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;

   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Sync flops reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         par_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         rx_meta_q  <= bus.rx;
         rx_s_q     <= rx_meta_q;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_pend_q <= par_pend_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q + CW'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_pend_d = par_pend_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      ferr_d     = ferr_q;
      perr_d     = perr_q;
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (clk_cnt_q == HALF_M1) begin
               clk_cnt_d = '0;
               if (!rx_s_q) begin
                  state_d    = S_DATA;
                  bit_idx_d  = '0;
                  par_pend_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + IW'(1);
               if (bit_idx_q == LAST_IDX) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d  = '0;
               par_pend_d = (^shift_q) ^ rx_s_q ^ 1'(PARITY_ODD);
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               valid_d   = 1'b1;
               data_d    = shift_q;
               ferr_d    = ~rx_s_q;
               perr_d    = par_pend_q;
               state_d   = rx_s_q ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            clk_cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = (state_q != S_IDLE);
      bus.state      = state_q;
      bus.rx_valid   = valid_q;
      bus.rx_data    = data_q;
      bus.frame_err  = ferr_q;
      bus.parity_err = perr_q;
   end
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one 8N1 instance and one 8E1 instance, each with its own line,
// expected words queued as frames are driven and compared as rx_valid strobes appear.
module tb_uart_receiver;
   localparam int CPB = 16;

   logic main_clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_errors;

   logic [9:0] exp_a_q[$];
   logic [9:0] exp_b_q[$];
   logic [9:0] ea, eb;
   logic       prev_va, prev_vb;
   int         last_valid_cyc;

   uart_receiver_if #(.DATA_BITS(8)) ifa ();
   uart_receiver_if #(.DATA_BITS(8)) ifb ();

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .main_clk (main_clk),
      .reset    (reset),
      .bus      (ifa.slave)
   );

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
      .main_clk (main_clk),
      .reset    (reset),
      .bus      (ifb.slave)
   );

   // clock / reset
   initial main_clk = 1'b0;
   always #5 main_clk = ~main_clk;
   always @(posedge main_clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic set_rx(input int which, input logic b);
      if (which == 0) ifa.rx = b;
      else            ifb.rx = b;
   endtask

   task automatic drive_bit(input int which, input logic b);
      set_rx(which, b);
      repeat (CPB) @(posedge main_clk);
      #1;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                             input logic par, input logic stop);
      drive_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
      if (par_en) drive_bit(which, par);
      drive_bit(which, stop);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge main_clk);
      #1;
   endtask

   task automatic wait_drain(input int which);
      for (int i = 0; i < 400; i++) begin
         if (which == 0 && exp_a_q.size() == 0) break;
         if (which == 1 && exp_b_q.size() == 0) break;
         @(posedge main_clk);
      end
      #1;
      if (which == 0) check("a_drain", exp_a_q.size(), 0);
      else            check("b_drain", exp_b_q.size(), 0);
   endtask

   // scoreboard: {parity_err, frame_err, data}
   always @(negedge main_clk) begin
      if (ifa.rx_valid) begin
         check("a_valid_width", prev_va, 0);
         check("a_valid_expected", exp_a_q.size() != 0, 1);
         if (exp_a_q.size() != 0) begin
            ea = exp_a_q.pop_front();
            check("a_data", ifa.rx_data, ea[7:0]);
            check("a_frame_err", ifa.frame_err, ea[8]);
            check("a_parity_err", ifa.parity_err, ea[9]);
         end
         last_valid_cyc = cyc;
      end
      prev_va = ifa.rx_valid;
   end

   always @(negedge main_clk) begin
      if (ifb.rx_valid) begin
         check("b_valid_width", prev_vb, 0);
         check("b_valid_expected", exp_b_q.size() != 0, 1);
         if (exp_b_q.size() != 0) begin
            eb = exp_b_q.pop_front();
            check("b_data", ifb.rx_data, eb[7:0]);
            check("b_frame_err", ifb.frame_err, eb[8]);
            check("b_parity_err", ifb.parity_err, eb[9]);
         end
      end
      prev_vb = ifb.rx_valid;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_data"}, ifa.rx_data, 0);
      check({tag, "_rx_valid"}, ifa.rx_valid, 0);
      check({tag, "_frame_err"}, ifa.frame_err, 0);
      check({tag, "_parity_err"}, ifa.parity_err, 0);
      check({tag, "_busy"}, ifa.busy, 0);
   endtask

   initial begin
      int t0;
      logic [7:0] r;
      cyc = 0;
      n_checks = 0;
      n_errors = 0;
      prev_va = 1'b0;
      prev_vb = 1'b0;
      last_valid_cyc = 0;
      ifa.rx = 1'b1;
      ifb.rx = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge main_clk);
      @(negedge main_clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      idle_cycles(5);

      // single 8N1 frame with latency measurement
      exp_a_q.push_back({1'b0, 1'b0, 8'hA5});
      t0 = cyc;
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      check("latency_in_window", (last_valid_cyc - t0 >= 153) && (last_valid_cyc - t0 <= 157), 1);
      idle_cycles(2);
      check("busy_after_frame", ifa.busy, 0);

      // back-to-back with no idle gap
      exp_a_q.push_back({1'b0, 1'b0, 8'h00});
      exp_a_q.push_back({1'b0, 1'b0, 8'hFF});
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
      wait_drain(0);

      // random back-to-back words
      for (int i = 0; i < 4; i++) begin
         r = 8'($urandom_range(0, 255));
         exp_a_q.push_back({1'b0, 1'b0, r});
         send_frame(0, r, 1'b0, 1'b0, 1'b1);
      end
      wait_drain(0);
      idle_cycles(20);

      // short low glitch on an idle line
      set_rx(0, 1'b0);
      idle_cycles(4);
      check("glitch_busy_high", ifa.busy, 1);
      idle_cycles(2);
      set_rx(0, 1'b1);
      idle_cycles(10);
      check("glitch_busy_low", ifa.busy, 0);
      idle_cycles(20);

      // stop bit low then line held in break
      exp_a_q.push_back({1'b0, 1'b1, 8'h3C});
      drive_bit(0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(0, r_bit(8'h3C, i));
      set_rx(0, 1'b0);
      idle_cycles(30);
      check("break_busy", ifa.busy, 1);
      check("break_frame_seen", exp_a_q.size(), 0);
      idle_cycles(10);
      set_rx(0, 1'b1);
      idle_cycles(5);
      check("break_release_busy", ifa.busy, 0);
      idle_cycles(40);

      // even parity on the parity instance
      exp_b_q.push_back({1'b0, 1'b0, 8'h07});
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      exp_b_q.push_back({1'b1, 1'b0, 8'h07});
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
      exp_b_q.push_back({1'b0, 1'b0, 8'hA5});
      send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1);
      exp_b_q.push_back({1'b1, 1'b0, 8'h80});
      send_frame(1, 8'h80, 1'b1, 1'b0, 1'b1);
      wait_drain(1);
      idle_cycles(20);

      // reset in the middle of a data phase
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, r_bit(8'h55, i));
      reset = 1'b1;
      ifa.rx = 1'b1;
      idle_cycles(2);
      @(negedge main_clk);
      check_reset_outputs("midframe_reset");
      reset = 1'b0;
      idle_cycles(200);
      check("no_valid_after_abort", exp_a_q.size(), 0);
      exp_a_q.push_back({1'b0, 1'b0, 8'h55});
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      idle_cycles(50);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   function automatic logic r_bit(input logic [7:0] d, input int i);
      return d[i];
   endfunction
endmodule
